key_pulse_gen: RTL and testbench
================================

KEY_PULSE_GEN -- requirements
Module: key_pulse_gen

Interface
REQ-001 Parameter CNT_MAX, default 1000000, SHALL set the debounce window in clk cycles (20 ms at 50 MHz); legal range 2..2^24-1.
REQ-002 clk  input  1  SHALL be the single system clock; all state changes on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous and active-high.
REQ-004 key_in  input  1  SHALL be the raw, asynchronous, active-low push-button level, which may bounce.
REQ-005 key_flag  output  1  SHALL be a one-cycle press pulse that drives the downstream counter carry-in (cin).
REQ-006 release_flag  output  1  SHALL be a one-cycle pulse on a debounced release.
REQ-007 key_state  output  1  SHALL be the debounced level: 1 = released, 0 = pressed.

Function
REQ-008 key_in SHALL pass through a two-flop synchronizer (s1, s2) followed by one history flop (s3).
REQ-009 Edges SHALL be derived only from s2 and s3: fall = s3 & ~s2; rise = ~s3 & s2.
REQ-010 The FSM SHALL have four states: IDLE (released), FILT_DN (press candidate), DOWN (pressed), FILT_UP (release candidate).
REQ-011 IDLE -> FILT_DN SHALL occur on fall; the debounce counter SHALL clear to 0 on entry.
REQ-012 In FILT_DN, each cycle with s2=0 SHALL increment the counter.
REQ-013 A rise while in FILT_DN SHALL return the FSM to IDLE with the counter cleared and no flag.
REQ-014 When the counter equals CNT_MAX-1 with s2=0, the FSM SHALL move FILT_DN -> DOWN and assert key_flag for exactly one cycle.
REQ-015 DOWN -> FILT_UP SHALL occur on rise and clear the counter.
REQ-016 FILT_UP SHALL mirror FILT_DN with polarity inverted: a fall returns to DOWN; counter reaching CNT_MAX-1 with s2=1 SHALL move to IDLE and pulse release_flag for one cycle.
REQ-017 key_state SHALL be 0 in DOWN and FILT_UP, and 1 in IDLE and FILT_DN.
REQ-018 All outputs SHALL be registered.
REQ-019 Latency from the first clk edge that samples a stable-low key_in to key_flag=1 SHALL be exactly CNT_MAX+3 cycles; release_flag latency SHALL be the same.
REQ-020 A key held indefinitely SHALL produce exactly one key_flag; there is no auto-repeat.
REQ-021 key_flag and release_flag SHALL never be high in the same cycle, and each SHALL be followed by at least CNT_MAX cycles low.
REQ-022 The counter SHALL be ceil(log2(CNT_MAX)) bits wide and SHALL never wrap: it holds only in FILT_DN and FILT_UP and is bounded by CNT_MAX-1.
REQ-023 Bounce pulses shorter than CNT_MAX cycles SHALL produce no flag and SHALL restart the window.

Reset
REQ-024 While rst=1, on each rising clk edge: s1=s2=s3=1, state=IDLE, counter=0, key_flag=0, release_flag=0, key_state=1.
REQ-025 rst asserted mid-filter or in DOWN SHALL abort the operation with no flag emitted.
REQ-026 After rst deasserts, a key_in already held low SHALL be treated as a new press: s2 falls after sync, giving fall and then key_flag after CNT_MAX+3 cycles.

Structure
REQ-027 A shared package SHALL hold the state encoding (2-bit: IDLE=0, FILT_DN=1, DOWN=2, FILT_UP=3) and the counter-width function.
REQ-028 The synchronizer and edge detector SHALL be one sub-module, key_sync_edge (outputs s2, fall, rise); the FSM and counter SHALL live in key_pulse_gen.
REQ-029 key_flag SHALL connect directly to the downstream counter carry-in with no extra logic.

Verification (CNT_MAX=10 for simulation)
REQ-030 Clean press: key_in 1->0 held 50 cycles -> key_flag=1 exactly 13 cycles after the sampling edge, high for 1 cycle; key_state=0 from the same cycle.
REQ-031 Bounce reject: key_in low 4 cycles, high 3, low 6, then high -> no key_flag; key_state stays 1.
REQ-032 Bouncy press: three sub-10-cycle glitches, then low held 40 cycles -> exactly one key_flag, 13 cycles after the final stable fall.
REQ-033 Release: after a press, key_in 0->1 held 30 cycles -> release_flag single pulse at 13 cycles; key_state=1; no key_flag.
REQ-034 Reset mid-filter: rst=1 for 2 cycles at counter=6 in FILT_DN -> no flag, state IDLE, key_state=1; key still low after rst drops -> key_flag 13 cycles later.
REQ-035 Chained with the 8-bit counter: 5 clean presses -> counter q increments by exactly 5; 256 presses -> q wraps to 0 and cout pulses once.

Source files
------------

// File: rtl/key_pulse_gen_pkg.sv
// Shared definitions for the debounced key pulse generator:
// FSM state encoding and the debounce counter width helper.
package key_pulse_gen_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FILT_DN = 2'd1,
      DOWN    = 2'd2,
      FILT_UP = 2'd3
   } key_state_t;

   // Smallest width that can hold values 0..n-1, never below one bit.
   function automatic int cnt_width(input int n);
      int w;
      w = 1;
      for (int i = 1; i < 31; i++) begin
         if ((32'sd1 <<< (i - 1)) < n) begin
            w = i;
         end else begin
            w = w;
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/key_sync_edge.sv
// Two-flop synchronizer for the raw key level plus one history flop;
// edges come only from the synchronized level and its delayed copy.
module key_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic key_in,
   output logic s2,
   output logic fall,
   output logic rise
);

   logic s1_r;
   logic s2_r;
   logic s3_r;

   // synchronizer chain, idles at the released (high) level
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_r <= 1'b1;
         s2_r <= 1'b1;
         s3_r <= 1'b1;
      end else begin
         s1_r <= key_in;
         s2_r <= s1_r;
         s3_r <= s2_r;
      end
   end

   assign s2   = s2_r;
   assign fall = s3_r & ~s2_r;
   assign rise = ~s3_r & s2_r;

endmodule

// File: rtl/key_pulse_gen.sv
// Debounced push-button: emits a one-cycle press pulse (drives a counter
// carry-in), a one-cycle release pulse and the debounced level.
module key_pulse_gen
   import key_pulse_gen_pkg::*;
#(
   parameter int unsigned CNT_MAX = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic key_in,
   output logic key_flag,
   output logic release_flag,
   output logic key_state
);

   localparam int CW = cnt_width(int'(CNT_MAX));
   localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 32'd1);

   logic s2_s;
   logic fall_s;
   logic rise_s;

   key_state_t    state_r;
   key_state_t    prev_r;
   key_state_t    state_s;
   logic [CW-1:0] cnt_r;
   logic [CW-1:0] cnt_s;
   logic          key_flag_r;
   logic          release_flag_r;
   logic          key_state_r;

   key_sync_edge u_sync (
      .clk    (clk),
      .rst    (rst),
      .key_in (key_in),
      .s2     (s2_s),
      .fall   (fall_s),
      .rise   (rise_s)
   );

   // state and debounce counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         prev_r  <= IDLE;
         cnt_r   <= {CW{1'b0}};
      end else begin
         state_r <= state_s;
         prev_r  <= state_r;
         cnt_r   <= cnt_s;
      end
   end

   // next-state logic; the counter is only non-zero inside a filter window
   always_comb begin
      state_s = state_r;
      cnt_s   = {CW{1'b0}};
      case (state_r)
         IDLE: begin
            if (fall_s) begin
               state_s = FILT_DN;
            end else begin
               state_s = IDLE;
            end
         end
         FILT_DN: begin
            if (!s2_s) begin
               if (cnt_r == CNT_LAST) begin
                  state_s = DOWN;
               end else begin
                  cnt_s = cnt_r + CW'(1);
               end
            end else begin
               state_s = IDLE;
            end
         end
         DOWN: begin
            if (rise_s) begin
               state_s = FILT_UP;
            end else begin
               state_s = DOWN;
            end
         end
         FILT_UP: begin
            if (s2_s) begin
               if (cnt_r == CNT_LAST) begin
                  state_s = IDLE;
               end else begin
                  cnt_s = cnt_r + CW'(1);
               end
            end else begin
               state_s = DOWN;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // pulses mark the completed filter transitions only, never an abort
   always_ff @(posedge clk) begin
      if (rst) begin
         key_flag_r     <= 1'b0;
         release_flag_r <= 1'b0;
         key_state_r    <= 1'b1;
      end else begin
         key_flag_r     <= (state_r == DOWN) && (prev_r == FILT_DN);
         release_flag_r <= (state_r == IDLE) && (prev_r == FILT_UP);
         key_state_r    <= (state_r == IDLE) || (state_r == FILT_DN);
      end
   end

   assign key_flag     = key_flag_r;
   assign release_flag = release_flag_r;
   assign key_state    = key_state_r;

endmodule

// File: tb/tb_key_pulse_gen.sv
// Directed bench for key_pulse_gen with CNT_MAX=10: a segment table of
// input levels with expected pulse positions, then a chained 8-bit counter.
module tb_key_pulse_gen;

   localparam int unsigned CNT_MAX = 10;

   logic clk;
   logic rst;
   logic key_in;
   logic key_flag;
   logic release_flag;
   logic key_state;

   int n_vec;
   int n_bad;

   logic [7:0] q;
   int         cout_n;

   typedef struct {
      logic rst;
      logic key;
      int   n;
      int   kf_at;
      int   rf_at;
      logic ks_start;
      int   ks_flip;
   } seg_t;

   seg_t segs [19];

   key_pulse_gen #(.CNT_MAX(CNT_MAX)) dut (
      .clk          (clk),
      .rst          (rst),
      .key_in       (key_in),
      .key_flag     (key_flag),
      .release_flag (release_flag),
      .key_state    (key_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // downstream 8-bit counter fed by key_flag as carry-in
   always_ff @(posedge clk) begin
      if (rst) begin
         q      <= 8'd0;
         cout_n <= 0;
      end else begin
         if (key_flag) begin
            q <= q + 8'd1;
            if (q == 8'hFF) cout_n <= cout_n + 1;
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press_release();
      key_in = 1'b0;
      repeat (16) tick();
      key_in = 1'b1;
      repeat (16) tick();
   endtask

   initial begin
      int kf_n, kf_t, rf_n, rf_t, both, ks_err;
      logic ks_exp;
      n_vec  = 0;
      n_bad  = 0;
      rst    = 1'b1;
      key_in = 1'b1;

      // rst key  n  kf  rf  ks  flip   (flag ticks: 13 edges after sampling edge)
      segs[0]  = '{1'b1, 1'b1,  3,  0,  0, 1'b1,  0};  // reset state
      segs[1]  = '{1'b0, 1'b0, 50, 14,  0, 1'b1, 14};  // clean press, no repeat
      segs[2]  = '{1'b0, 1'b1, 30,  0, 14, 1'b0, 14};  // release
      segs[3]  = '{1'b0, 1'b0,  4,  0,  0, 1'b1,  0};  // bounce reject
      segs[4]  = '{1'b0, 1'b1,  3,  0,  0, 1'b1,  0};
      segs[5]  = '{1'b0, 1'b0,  6,  0,  0, 1'b1,  0};
      segs[6]  = '{1'b0, 1'b1, 20,  0,  0, 1'b1,  0};
      segs[7]  = '{1'b0, 1'b0,  3,  0,  0, 1'b1,  0};  // bouncy press
      segs[8]  = '{1'b0, 1'b1,  5,  0,  0, 1'b1,  0};
      segs[9]  = '{1'b0, 1'b0,  7,  0,  0, 1'b1,  0};
      segs[10] = '{1'b0, 1'b1,  2,  0,  0, 1'b1,  0};
      segs[11] = '{1'b0, 1'b0,  9,  0,  0, 1'b1,  0};
      segs[12] = '{1'b0, 1'b1,  4,  0,  0, 1'b1,  0};
      segs[13] = '{1'b0, 1'b0, 40, 14,  0, 1'b1, 14};
      segs[14] = '{1'b0, 1'b1, 30,  0, 14, 1'b0, 14};
      segs[15] = '{1'b0, 1'b0,  9,  0,  0, 1'b1,  0};  // counter at 6 in FILT_DN
      segs[16] = '{1'b1, 1'b0,  2,  0,  0, 1'b1,  0};  // reset mid-filter
      segs[17] = '{1'b0, 1'b0, 30, 14,  0, 1'b1, 14};  // held key is a new press
      segs[18] = '{1'b0, 1'b1, 30,  0, 14, 1'b0, 14};

      for (int i = 0; i < 19; i++) begin
         rst    = segs[i].rst;
         key_in = segs[i].key;
         kf_n = 0; kf_t = 0; rf_n = 0; rf_t = 0; both = 0; ks_err = 0;
         for (int t = 1; t <= segs[i].n; t++) begin
            tick();
            if (key_flag === 1'b1) begin
               kf_n++;
               if (kf_t == 0) kf_t = t;
            end
            if (release_flag === 1'b1) begin
               rf_n++;
               if (rf_t == 0) rf_t = t;
            end
            if (key_flag === 1'b1 && release_flag === 1'b1) both++;
            if (segs[i].ks_flip != 0 && t >= segs[i].ks_flip)
               ks_exp = ~segs[i].ks_start;
            else
               ks_exp = segs[i].ks_start;
            if (key_state !== ks_exp) ks_err++;
         end
         check($sformatf("seg%0d key_flag count", i), kf_n, (segs[i].kf_at != 0) ? 1 : 0);
         check($sformatf("seg%0d key_flag tick", i), kf_t, segs[i].kf_at);
         check($sformatf("seg%0d release_flag count", i), rf_n, (segs[i].rf_at != 0) ? 1 : 0);
         check($sformatf("seg%0d release_flag tick", i), rf_t, segs[i].rf_at);
         check($sformatf("seg%0d both flags", i), both, 0);
         check($sformatf("seg%0d key_state", i), ks_err, 0);
      end

      // chained counter: clear it, 5 presses, then 251 more to wrap
      key_in = 1'b1;
      rst    = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      repeat (4) tick();
      check("counter after reset", int'(q), 0);
      for (int p = 0; p < 5; p++) press_release();
      check("counter after 5 presses", int'(q), 5);
      check("cout before wrap", cout_n, 0);
      for (int p = 0; p < 251; p++) press_release();
      check("counter after 256 presses", int'(q), 0);
      check("cout after wrap", cout_n, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
